btb_set_assoc: RTL



---
 rtl/btb_set_assoc_if.sv | 33 +++
 rtl/btb_set_assoc.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/btb_set_assoc_if.sv
// Fetch/execute-side bundle for the set-associative BTB: lookup, training,
// flush and performance counter signals.
interface btb_set_assoc_if #(
   parameter int PC_W  = 32,
   parameter int CNT_W = 32
);
   logic             lookup_valid;
   logic [PC_W-1:0]  lookup_pc;
   logic             hit;
   logic             pred_taken;
   logic [PC_W-1:0]  pred_target;
   logic             upd_valid;
   logic [PC_W-1:0]  upd_pc;
   logic             upd_taken;
   logic [PC_W-1:0]  upd_target;
   logic             upd_mispredict;
   logic             flush_all;
   logic [CNT_W-1:0] perf_lookups;
   logic [CNT_W-1:0] perf_hits;
   logic [CNT_W-1:0] perf_mispredicts;

   modport master (
      output lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
             upd_mispredict, flush_all,
      input  hit, pred_taken, pred_target, perf_lookups, perf_hits, perf_mispredicts
   );

   modport slave (
      input  lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
             upd_mispredict, flush_all,
      output hit, pred_taken, pred_target, perf_lookups, perf_hits, perf_mispredicts
   );
endinterface

// File: rtl/btb_set_assoc.sv
// Set-associative branch target buffer with saturating direction counters and
// round-robin replacement. Define BTB_PERF_CNT_EN to build the performance counters.
module btb_set_assoc #(
   parameter int PC_W  = 32,
   parameter int SETS  = 16,
   parameter int WAYS  = 2,
   parameter int CTR_W = 2,
   parameter int CNT_W = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   btb_set_assoc_if.slave  bus
);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = PC_W - IDX_W - 2;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(1) << (CTR_W - 1);

   logic [WAYS-1:0]  valid_reg  [SETS];
   logic [WAY_W-1:0] ptr_reg    [SETS];
   logic [TAG_W-1:0] tag_reg    [SETS][WAYS];
   logic [PC_W-1:0]  target_reg [SETS][WAYS];
   logic [CTR_W-1:0] ctr_reg    [SETS][WAYS];

   logic [IDX_W-1:0] lk_idx, up_idx;
   logic [TAG_W-1:0] lk_tag, up_tag;
   logic [WAYS-1:0]  lk_match, up_match, wr_way;
   logic [CTR_W-1:0] ctr_next [WAYS];
   logic [PC_W-1:0]  lk_target;
   logic             lk_msb;
   logic             up_hit, inv_found, do_write;
   logic [WAY_W-1:0] inv_way, victim, ptr_adv;

   assign lk_idx = bus.lookup_pc[IDX_W+1:2];
   assign lk_tag = bus.lookup_pc[PC_W-1:IDX_W+2];
   assign up_idx = bus.upd_pc[IDX_W+1:2];
   assign up_tag = bus.upd_pc[PC_W-1:IDX_W+2];

   generate
      for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
         assign lk_match[gi] = valid_reg[lk_idx][gi] && (tag_reg[lk_idx][gi] == lk_tag);
         assign up_match[gi] = valid_reg[up_idx][gi] && (tag_reg[up_idx][gi] == up_tag);
         // A tag hit always wins over allocation, so entries never duplicate.
         assign wr_way[gi]   = up_hit ? up_match[gi] : (victim == WAY_W'(gi));

         always_comb begin
            ctr_next[gi] = ctr_reg[up_idx][gi];
            if (bus.upd_taken) begin
               if (ctr_reg[up_idx][gi] != {CTR_W{1'b1}})
                  ctr_next[gi] = ctr_reg[up_idx][gi] + 1'b1;
            end else if (ctr_reg[up_idx][gi] != '0) begin
               ctr_next[gi] = ctr_reg[up_idx][gi] - 1'b1;
            end
         end
      end
   endgenerate

   always_comb begin
      lk_target = '0;
      lk_msb    = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (lk_match[w]) begin
            lk_target = target_reg[lk_idx][w];
            lk_msb    = ctr_reg[lk_idx][w][CTR_W-1];
         end
      end
   end

   assign bus.hit         = bus.lookup_valid && (|lk_match);
   assign bus.pred_taken  = bus.hit && lk_msb;
   assign bus.pred_target = bus.pred_taken ? lk_target : bus.lookup_pc + PC_W'(4);

   // Lowest-index invalid way; scanning downward lets the lowest one win.
   always_comb begin
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_reg[up_idx][w]) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
   end

   assign up_hit   = |up_match;
   assign victim   = inv_found ? inv_way : ptr_reg[up_idx];
   assign ptr_adv  = (ptr_reg[up_idx] == WAY_W'(WAYS - 1)) ? '0 : ptr_reg[up_idx] + 1'b1;
   assign do_write = reset_n && bus.upd_valid && !bus.flush_all && (up_hit || bus.upd_taken);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < SETS; s++) begin
            valid_reg[s] <= '0;
            ptr_reg[s]   <= '0;
         end
      end else if (bus.flush_all) begin
         for (int s = 0; s < SETS; s++) begin
            valid_reg[s] <= '0;
            ptr_reg[s]   <= '0;
         end
      end else if (do_write && !up_hit) begin
         valid_reg[up_idx] <= valid_reg[up_idx] | wr_way;
         if (!inv_found)
            ptr_reg[up_idx] <= ptr_adv;
      end
   end

   // Payload arrays carry no reset; a cleared valid bit makes them don't-care.
   always_ff @(posedge clk) begin
      for (int w = 0; w < WAYS; w++) begin
         if (do_write && wr_way[w]) begin
            tag_reg[up_idx][w] <= up_tag;
            ctr_reg[up_idx][w] <= up_hit ? ctr_next[w] : CTR_ALLOC;
            if (bus.upd_taken)
               target_reg[up_idx][w] <= bus.upd_target;
         end
      end
   end

`ifdef BTB_PERF_CNT_EN
   logic [CNT_W-1:0] lookups_reg, hits_reg, mispredicts_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lookups_reg     <= '0;
         hits_reg        <= '0;
         mispredicts_reg <= '0;
      end else begin
         if (bus.lookup_valid)
            lookups_reg <= lookups_reg + 1'b1;
         if (bus.hit)
            hits_reg <= hits_reg + 1'b1;
         if (bus.upd_valid && bus.upd_mispredict)
            mispredicts_reg <= mispredicts_reg + 1'b1;
      end
   end

   assign bus.perf_lookups     = lookups_reg;
   assign bus.perf_hits        = hits_reg;
   assign bus.perf_mispredicts = mispredicts_reg;
`else
   assign bus.perf_lookups     = '0;
   assign bus.perf_hits        = '0;
   assign bus.perf_mispredicts = '0;
`endif

   logic unused_bits;
   assign unused_bits = ^{bus.upd_pc[1:0], bus.upd_mispredict};
endmodule
